// File: rtl/wb_stage_multilane.sv
// wb_stage_multilane
// Writeback stage for a LANES-wide superscalar bundle (lane 0 is oldest).
// Holds the MEM2 -> WB stage register, performs per-lane load alignment and
// extension (including the LWL/LWR merge), selects the final result and
// drives the register-file write enables. It also tracks which lanes have
// already retired, so an instruction held across stalls writes and retires
// exactly once. It suppresses older same-bundle writes to the same
// destination and counts retired instructions.
//
// Ports:
//   clk, resetn         clock, asynchronous active-low reset
//   wb_flush            clear stage contents (priority over wb_wr)
//   wb_wr               load stage register from MEM2
//   wb_diswr            DCache stall, blocks RF write and commit this cycle
//   m2_*                per-lane MEM2 inputs (packed, lane i at slice i)
//   wb_valid/regwr/dst/pc  registered lane fields
//   wb_result           final writeback data
//   wb_final_wr         RF write enable per lane
//   wb_commit           lane retires this cycle
//   retire_cnt          running retired-instruction count (wraps)
module wb_stage_multilane #(
  parameter int LANES = 2,
  parameter int CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  wb_flush,
  input  logic                  wb_wr,
  input  logic                  wb_diswr,
  input  logic [LANES-1:0]      m2_valid,
  input  logic [LANES-1:0]      m2_regwr,
  input  logic [5*LANES-1:0]    m2_dst,
  input  logic [32*LANES-1:0]   m2_pc,
  input  logic [32*LANES-1:0]   m2_result,
  input  logic [32*LANES-1:0]   m2_aluout,
  input  logic [32*LANES-1:0]   m2_dmout,
  input  logic [32*LANES-1:0]   m2_outb,
  input  logic [3*LANES-1:0]    m2_loadtype,
  input  logic [2*LANES-1:0]    m2_wbsel,
  output logic [LANES-1:0]      wb_valid,
  output logic [LANES-1:0]      wb_regwr,
  output logic [5*LANES-1:0]    wb_dst,
  output logic [32*LANES-1:0]   wb_pc,
  output logic [32*LANES-1:0]   wb_result,
  output logic [LANES-1:0]      wb_final_wr,
  output logic [LANES-1:0]      wb_commit,
  output logic [CNT_W-1:0]      retire_cnt
);

  logic [LANES-1:0]    r_valid;
  logic [LANES-1:0]    r_regwr;
  logic [5*LANES-1:0]  r_dst;
  logic [32*LANES-1:0] r_pc;
  logic [32*LANES-1:0] r_result;
  logic [2*LANES-1:0]  r_addr_lo;
  logic [32*LANES-1:0] r_dmout;
  logic [32*LANES-1:0] r_outb;
  logic [3*LANES-1:0]  r_loadtype;
  logic [2*LANES-1:0]  r_wbsel;
  logic [LANES-1:0]    r_committed;
  logic [CNT_W-1:0]    r_retire_cnt;

  logic [LANES-1:0]    w_commit;
  logic [LANES-1:0]    w_killed;
  logic [LANES-1:0]    w_final_wr;
  logic [32*LANES-1:0] w_result;
  logic [CNT_W-1:0]    w_pop;
  logic [2*LANES-1:0]  w_addr_lo;
  logic                w_unused_aluout;

  // Only the byte offset of the effective address is needed downstream.
  always_comb begin
    w_addr_lo = '0;
    for (int i = 0; i < LANES; i++) begin
      w_addr_lo[2*i +: 2] = m2_aluout[32*i +: 2];
    end
  end
  assign w_unused_aluout = ^m2_aluout;

  // Little-endian load alignment; k is the byte offset within the word.
  function automatic logic [31:0] load_ext(input logic [2:0]  lt,
                                           input logic [1:0]  k,
                                           input logic [31:0] dm,
                                           input logic [31:0] ob);
    logic [4:0]  sh_r;
    logic [4:0]  sh_l;
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;
    sh_r    = {k, 3'b000};
    sh_l    = {~k, 3'b000};   // 8*(3-k)
    shifted = dm >> sh_r;
    b       = shifted[7:0];
    h       = k[1] ? dm[31:16] : dm[15:0];
    case (lt)
      3'd1:    load_ext = {{24{b[7]}}, b};
      3'd2:    load_ext = {24'd0, b};
      3'd3:    load_ext = {{16{h[15]}}, h};
      3'd4:    load_ext = {16'd0, h};
      3'd5:    load_ext = (dm << sh_l) | (ob & ((32'h1 << sh_l) - 32'h1));
      3'd6:    load_ext = (dm >> sh_r) | (ob & ~(32'hFFFF_FFFF >> sh_r));
      default: load_ext = dm;
    endcase
  endfunction

  always_comb begin
    w_commit   = r_valid & ~r_committed & {LANES{~wb_diswr}};
    w_killed   = '0;
    w_final_wr = '0;
    w_result   = '0;
    w_pop      = '0;
    for (int i = 0; i < LANES; i++) begin
      // A younger writer of the same register makes this lane's write dead.
      for (int j = i + 1; j < LANES; j++) begin
        if (r_valid[j] && r_regwr[j] && (r_dst[5*j +: 5] == r_dst[5*i +: 5])) begin
          w_killed[i] = 1'b1;
        end
      end
      w_final_wr[i] = w_commit[i] & r_regwr[i] & (r_dst[5*i +: 5] != 5'd0) & ~w_killed[i];
      w_result[32*i +: 32] = (r_wbsel[2*i +: 2] == 2'b11)
                           ? load_ext(r_loadtype[3*i +: 3], r_addr_lo[2*i +: 2],
                                      r_dmout[32*i +: 32], r_outb[32*i +: 32])
                           : r_result[32*i +: 32];
      w_pop = w_pop + CNT_W'(w_commit[i]);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_valid      <= '0;
      r_regwr      <= '0;
      r_dst        <= '0;
      r_pc         <= '0;
      r_result     <= '0;
      r_addr_lo    <= '0;
      r_dmout      <= '0;
      r_outb       <= '0;
      r_loadtype   <= '0;
      r_wbsel      <= '0;
      r_committed  <= '0;
      r_retire_cnt <= '0;
    end else begin
      if (wb_flush) begin
        r_valid     <= '0;
        r_regwr     <= '0;
        r_dst       <= '0;
        r_pc        <= '0;
        r_result    <= '0;
        r_addr_lo   <= '0;
        r_dmout     <= '0;
        r_outb      <= '0;
        r_loadtype  <= '0;
        r_wbsel     <= '0;
        r_committed <= '0;
      end else if (wb_wr) begin
        r_valid     <= m2_valid;
        r_regwr     <= m2_regwr;
        r_dst       <= m2_dst;
        r_pc        <= m2_pc;
        r_result    <= m2_result;
        r_addr_lo   <= w_addr_lo;
        r_dmout     <= m2_dmout;
        r_outb      <= m2_outb;
        r_loadtype  <= m2_loadtype;
        r_wbsel     <= m2_wbsel;
        r_committed <= '0;
      end else begin
        // Held contents remember what already retired.
        r_committed <= r_committed | w_commit;
      end
      r_retire_cnt <= r_retire_cnt + w_pop;
    end
  end

  assign wb_valid    = r_valid;
  assign wb_regwr    = r_regwr;
  assign wb_dst      = r_dst;
  assign wb_pc       = r_pc;
  assign wb_result   = w_result;
  assign wb_final_wr = w_final_wr;
  assign wb_commit   = w_commit;
  assign retire_cnt  = r_retire_cnt;

endmodule

// File: doc/wb_stage_multilane.md
Name: wb_stage_multilane

Overview:
- Parametrised writeback stage for the superscalar pipeline. It replaces the single-lane MEM2→WB register, load-extension and result-select path.
- Latches LANES instruction slots from MEM2 and performs per-lane load alignment/extension, including LWL/LWR merge. It selects the final result and drives the register-file write ports.
- Adds one-shot commit tracking: each instruction writes and retires exactly once, even across stalls.
- Adds same-bundle write-after-write suppression and a retired-instruction counter.

Parameters:
- LANES, 2, number of instruction slots per bundle (1..4); lane 0 is oldest.
- CNT_W, 32, width of retired-instruction counter (8..64).

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- wb_flush  in  1  clear stage contents
- wb_wr  in  1  load stage register from MEM2
- wb_diswr  in  1  DCache stall; suppresses RF write and commit this cycle
- m2_valid  in  LANES  lane holds a real instruction
- m2_regwr  in  LANES  lane writes a GPR
- m2_dst  in  5*LANES  destination GPR
- m2_pc  in  32*LANES  instruction PC
- m2_result  in  32*LANES  non-load result
- m2_aluout  in  32*LANES  load effective address (bits [1:0] used)
- m2_dmout  in  32*LANES  raw DCache word
- m2_outb  in  32*LANES  old rt value, used for LWL/LWR merge
- m2_loadtype  in  3*LANES  0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LWL, 6 LWR, 7 treated as LW
- m2_wbsel  in  2*LANES  2'b11 selects load result, else m2_result
- wb_valid  out  LANES  registered valid
- wb_regwr  out  LANES  registered regwr, ungated (for forwarding/hazard)
- wb_dst  out  5*LANES  registered dst
- wb_pc  out  32*LANES  registered PC
- wb_result  out  32*LANES  final writeback data (combinational from stage register)
- wb_final_wr  out  LANES  RF write enable
- wb_commit  out  LANES  lane retires this cycle
- retire_cnt  out  CNT_W  retired-instruction count

Behaviour:
- Reset (async, resetn=0): all stage registers, committed bits and retire_cnt go to 0. All outputs therefore read 0. Reset mid-stall discards contents; no write is issued.
- Stage register update:
  - wb_flush=1: valid, regwr, dst, pc, data and committed bits are cleared. Flush has priority over wb_wr.
  - else wb_wr=1: all fields load from MEM2 and committed bits clear.
  - else: hold.
- Latency: MEM2 inputs appear on outputs 1 cycle after the wb_wr edge.
- Load extension per lane (little-endian), with k = aluout[1:0]:
  - LB/LBU: byte k, sign- or zero-extended.
  - LH/LHU: half k[1], sign- or zero-extended; k[0] ignored.
  - LW: dmout unchanged.
  - LWL: (dmout << 8*(3-k)) | (outb & ((1<<8*(3-k))-1)).
  - LWR: (dmout >> 8*k) | (outb & ~(32'hFFFFFFFF >> 8*k)).
- wb_result lane = (wbsel==2'b11) ? extended load : result.
- commit_ok lane = valid & ~committed & ~wb_diswr.
- wb_commit = commit_ok.
- wb_final_wr lane = commit_ok & regwr & (dst≠0) & ~killed.
- killed lane i: some younger lane j>i has valid, regwr and dst_j==dst_i. The youngest writer wins.
- Committed bit for a lane sets on any cycle its commit_ok=1 and the register is not reloaded or flushed that edge. A held instruction therefore never writes or retires twice.
- A lane committing on the same edge as wb_wr/wb_flush counts once; the new contents start uncommitted.
- retire_cnt += popcount(wb_commit) each cycle, modulo 2^CNT_W, wrapping silently.
- wb_diswr=1 gates only commit/write; it does not affect register updates.

Test Plan:
- Reset: hold resetn=0 with random inputs → all outputs 0. Release, no wb_wr → outputs stay 0.
- LB sign-extend: lane0 dmout=32'h80FF7F01, aluout=...2, loadtype=1, wbsel=3, regwr, dst=5, wb_wr pulse → next cycle wb_result0=32'hFFFFFFFF, wb_final_wr0=1. Same with LBU → 32'h000000FF.
- LWL/LWR merge: dmout=32'h44332211, outb=32'hAABBCCDD, aluout[1:0]=1:
  - LWL → 32'h2211CCDD.
  - LWR → 32'hAA443322.
- WAW/zero: both lanes valid, regwr, dst=7 → final_wr=2'b10, commit=2'b11, retire_cnt +2. Lane0 dst=0 → final_wr0=0 but commit0=1.
- Stall: load bundle, hold wb_wr=0 with wb_diswr=1 for 3 cycles → final_wr=0, count unchanged. Drop wb_diswr for 4 cycles → final_wr asserts exactly one cycle, retire_cnt +LANES once.
- Flush priority and wrap:
  - wb_flush=1 with wb_wr=1 → valid=0, no commit.
  - CNT_W=8, counter preset via 255 retirements → next single retirement reads 0.
